// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared types and constants for the host-side USB sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package usb_pkg;

    typedef enum logic {
        TXN_OUT = 1'b0,
        TXN_IN  = 1'b1
    } txn_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR_ISSUE = 3'd1,
        ST_ADDR_WAIT  = 3'd2,
        ST_DATA_ISSUE = 3'd3,
        ST_DATA_WAIT  = 3'd4,
        ST_RESP       = 3'd5
    } rw_state_t;

    localparam logic [3:0] ADDR_LEN = 4'd2;
    localparam logic [3:0] DATA_LEN = 4'd8;

endpackage
`default_nettype wire

// File: rtl/usb_rw_fsm.sv
`default_nettype none
// ============================================================================
// Module      : usb_rw_fsm
// Description : Turns one memory request into an address OUT plus a data
//               OUT/IN transaction, retrying each phase, one response each.
// Revision    : 1.0  initial release
// ============================================================================
module usb_rw_fsm
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_success,
    output logic [63:0] resp_rdata,
    output logic        txn_start,
    output logic        txn_kind,
    output logic [6:0]  txn_dev,
    output logic [3:0]  txn_endp,
    output logic [3:0]  txn_len,
    output logic [63:0] txn_data,
    input  logic        txn_done,
    input  logic        txn_ok,
    input  logic [63:0] txn_rdata
);

    localparam int              CNT_W   = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RETRY);

    rw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [15:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;

    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_success_q, resp_success_d;
    logic [63:0]      resp_rdata_q, resp_rdata_d;
    logic             txn_start_q, txn_start_d;
    txn_kind_t        txn_kind_q, txn_kind_d;
    logic [3:0]       txn_endp_q, txn_endp_d;
    logic [3:0]       txn_len_q, txn_len_d;
    logic [63:0]      txn_data_q, txn_data_d;

    logic             launch_addr;
    logic             launch_data;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        resp_valid_d   = 1'b0;
        resp_success_d = 1'b0;
        resp_rdata_d   = 64'd0;
        txn_start_d    = 1'b0;
        txn_kind_d     = txn_kind_q;
        txn_endp_d     = txn_endp_q;
        txn_len_d      = txn_len_q;
        txn_data_d     = txn_data_q;
        launch_addr    = 1'b0;
        launch_data    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = '0;
                    state_d     = ST_ADDR_ISSUE;
                    launch_addr = 1'b1;
                end
            end
            ST_ADDR_ISSUE, ST_DATA_ISSUE: begin
                // Saturating so the counter can never wrap back below the limit
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                state_d = (state_q == ST_ADDR_ISSUE) ? ST_ADDR_WAIT : ST_DATA_WAIT;
            end
            ST_ADDR_WAIT: begin
                if (txn_done) begin
                    if (txn_ok) begin
                        cnt_d       = '0;
                        state_d     = ST_DATA_ISSUE;
                        launch_data = 1'b1;
                    end else if (cnt_q < CNT_MAX) begin
                        state_d     = ST_ADDR_ISSUE;
                        launch_addr = 1'b1;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            ST_DATA_WAIT: begin
                if (txn_done) begin
                    if (txn_ok) begin
                        state_d        = ST_RESP;
                        resp_valid_d   = 1'b1;
                        resp_success_d = 1'b1;
                        resp_rdata_d   = write_q ? 64'd0 : txn_rdata;
                    end else if (cnt_q < CNT_MAX) begin
                        state_d     = ST_DATA_ISSUE;
                        launch_data = 1'b1;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d    = ST_IDLE;
                txn_kind_d = TXN_OUT;
                txn_endp_d = 4'd0;
                txn_len_d  = 4'd0;
                txn_data_d = 64'd0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so the launch is programmed one cycle ahead
        if (launch_addr) begin
            txn_start_d = 1'b1;
            txn_kind_d  = TXN_OUT;
            txn_endp_d  = ADDR_ENDP;
            txn_len_d   = ADDR_LEN;
            txn_data_d  = {48'd0, addr_d};
        end
        if (launch_data) begin
            txn_start_d = 1'b1;
            txn_endp_d  = DATA_ENDP;
            txn_kind_d  = write_q ? TXN_OUT : TXN_IN;
            txn_len_d   = write_q ? DATA_LEN : 4'd0;
            txn_data_d  = write_q ? wdata_q : 64'd0;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            write_q        <= 1'b0;
            addr_q         <= 16'd0;
            wdata_q        <= 64'd0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_success_q <= 1'b0;
            resp_rdata_q   <= 64'd0;
            txn_start_q    <= 1'b0;
            txn_kind_q     <= TXN_OUT;
            txn_endp_q     <= 4'd0;
            txn_len_q      <= 4'd0;
            txn_data_q     <= 64'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            write_q        <= write_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_success_q <= resp_success_d;
            resp_rdata_q   <= resp_rdata_d;
            txn_start_q    <= txn_start_d;
            txn_kind_q     <= txn_kind_d;
            txn_endp_q     <= txn_endp_d;
            txn_len_q      <= txn_len_d;
            txn_data_q     <= txn_data_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_success = resp_success_q;
    assign resp_rdata   = resp_rdata_q;
    assign txn_start    = txn_start_q;
    assign txn_kind     = txn_kind_q;
    assign txn_dev      = DEV_ADDR;
    assign txn_endp     = txn_endp_q;
    assign txn_len      = txn_len_q;
    assign txn_data     = txn_data_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rw_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rw_fsm
// Description : Self-checking bench for usb_rw_fsm with a scripted protocol
//               layer and an attempt-count reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_usb_rw_fsm;

    localparam int MAXR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_success;
    logic [63:0] resp_rdata;
    logic        txn_start;
    logic        txn_kind;
    logic [6:0]  txn_dev;
    logic [3:0]  txn_endp;
    logic [3:0]  txn_len;
    logic [63:0] txn_data;
    logic        txn_done = 1'b0;
    logic        txn_ok = 1'b0;
    logic [63:0] txn_rdata = 64'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    usb_rw_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_success (resp_success),
        .resp_rdata   (resp_rdata),
        .txn_start    (txn_start),
        .txn_kind     (txn_kind),
        .txn_dev      (txn_dev),
        .txn_endp     (txn_endp),
        .txn_len      (txn_len),
        .txn_data     (txn_data),
        .txn_done     (txn_done),
        .txn_ok       (txn_ok),
        .txn_rdata    (txn_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        int          af;
        int          df;
        int          lat;
        logic        exp_succ;
        logic [63:0] exp_rdata;
        int          exp_starts;
        int          exp_lat;
    } vec_t;

    // Expectations from the request-level rules: attempts per phase are capped
    // at MAXR, each attempt costs 2 + lat cycles, plus one cycle for the response.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int a_att, d_att;
        a_att = (v.af >= MAXR) ? MAXR : v.af + 1;
        d_att = (v.af >= MAXR) ? 0 : ((v.df >= MAXR) ? MAXR : v.df + 1);
        r.exp_succ   = (v.af < MAXR) && (v.df < MAXR);
        r.exp_rdata  = (r.exp_succ && !v.wr) ? v.rd : 64'd0;
        r.exp_starts = a_att + d_att;
        r.exp_lat    = (a_att + d_att) * (2 + v.lat) + 1;
        return r;
    endfunction

    task automatic run_req(input vec_t v, input string tag);
        int   a_att, starts, done_cyc, k, resp_cyc;
        logic pending, cur_ok, got_resp;
        a_att    = (v.af >= MAXR) ? MAXR : v.af + 1;
        starts   = 0;
        pending  = 1'b0;
        cur_ok   = 1'b0;
        done_cyc = -1;
        got_resp = 1'b0;
        resp_cyc = -1;
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
        chk({tag, " ready_before"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        txn_rdata = v.wr ? {$urandom, $urandom} : v.rd;
        for (int cyc = 1; cyc < 400 && !got_resp; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            txn_done  = 1'b0;
            if (cyc == 1) chk({tag, " busy_ready"}, {63'd0, req_ready}, 64'd0);
            if (txn_start) begin
                starts++;
                if (starts <= a_att) begin
                    k      = starts;
                    cur_ok = (k > v.af);
                    chk({tag, " a_kind"}, {63'd0, txn_kind}, 64'd0);
                    chk({tag, " a_endp"}, {60'd0, txn_endp}, 64'd4);
                    chk({tag, " a_len"},  {60'd0, txn_len}, 64'd2);
                    chk({tag, " a_data"}, txn_data, {48'd0, v.addr});
                end else begin
                    k      = starts - a_att;
                    cur_ok = (k > v.df);
                    chk({tag, " d_kind"}, {63'd0, txn_kind}, v.wr ? 64'd0 : 64'd1);
                    chk({tag, " d_endp"}, {60'd0, txn_endp}, 64'd8);
                    chk({tag, " d_len"},  {60'd0, txn_len}, v.wr ? 64'd8 : 64'd0);
                    chk({tag, " d_data"}, txn_data, v.wr ? v.wdata : 64'd0);
                end
                chk({tag, " dev"}, {57'd0, txn_dev}, 64'd5);
                pending  = 1'b1;
                done_cyc = cyc + 1 + v.lat;
            end
            if (resp_valid) begin
                got_resp = 1'b1;
                resp_cyc = cyc;
            end
            if (pending && cyc == done_cyc) begin
                txn_done = 1'b1;
                txn_ok   = cur_ok;
                pending  = 1'b0;
            end
        end
        txn_done = 1'b0;
        if (!got_resp) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no resp_valid within cycle budget", tag);
        end else begin
            chk({tag, " latency"}, 64'(resp_cyc), 64'(v.exp_lat));
            chk({tag, " starts"},  64'(starts), 64'(v.exp_starts));
            chk({tag, " success"}, {63'd0, resp_success}, {63'd0, v.exp_succ});
            chk({tag, " rdata"},   resp_rdata, v.exp_rdata);
        end
        @(negedge clk);
        chk({tag, " resp_pulse"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, " idle_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, " idle_len"},   {60'd0, txn_len}, 64'd0);
    endtask

    vec_t tbl[6];

    initial begin
        int   starts, r1, done_cyc, resps, errs;
        logic ok2;
        vec_t v;

        tbl[0] = '{1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0,
                   1'b1, 64'd0, 2, 5};
        tbl[1] = '{1'b0, 16'h0040, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0,
                   1'b1, 64'hDEAD_BEEF_0123_4567, 2, 5};
        tbl[2] = '{1'b1, 16'h1234, 64'h0102_0304_0506_0708, 64'd0, 2, 0, 0,
                   1'b1, 64'd0, 4, 9};
        tbl[3] = '{1'b0, 16'h0ABC, 64'd0, 64'h5555_AAAA_5555_AAAA, 0, 8, 0,
                   1'b0, 64'd0, 9, 19};
        tbl[4] = '{1'b1, 16'h8001, 64'hCAFE_F00D_CAFE_F00D, 64'd0, 8, 0, 1,
                   1'b0, 64'd0, 8, 25};
        tbl[5] = '{1'b0, 16'h7FFE, 64'd0, 64'h0F0F_1234_8765_F0F0, 0, 7, 2,
                   1'b1, 64'h0F0F_1234_8765_F0F0, 9, 37};

        // Reset with a stale txn_done from before reset still asserted
        txn_done = 1'b1;
        txn_ok   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst req_ready",   {63'd0, req_ready}, 64'd1);
        chk("rst resp_valid",  {63'd0, resp_valid}, 64'd0);
        chk("rst resp_succ",   {63'd0, resp_success}, 64'd0);
        chk("rst resp_rdata",  resp_rdata, 64'd0);
        chk("rst txn_start",   {63'd0, txn_start}, 64'd0);
        chk("rst txn_kind",    {63'd0, txn_kind}, 64'd0);
        chk("rst txn_dev",     {57'd0, txn_dev}, 64'd5);
        chk("rst txn_endp",    {60'd0, txn_endp}, 64'd0);
        chk("rst txn_len",     {60'd0, txn_len}, 64'd0);
        chk("rst txn_data",    txn_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        txn_done = 1'b0;
        chk("stale_done start", {63'd0, txn_start}, 64'd0);
        chk("stale_done resp",  {63'd0, resp_valid}, 64'd0);
        chk("stale_done ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 6; i++) run_req(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting on the data phase, then a late completion
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h2222;
        starts    = 0;
        for (int cyc = 1; cyc < 20 && starts < 2; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            txn_done  = 1'b0;
            if (txn_start) begin
                starts++;
                done_cyc = cyc + 1;
            end
            if (starts == 1 && cyc == done_cyc) begin
                txn_done = 1'b1;
                txn_ok   = 1'b1;
            end
        end
        chk("midrst data_start", 64'(starts), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst ready",   {63'd0, req_ready}, 64'd1);
        chk("midrst resp",    {63'd0, resp_valid}, 64'd0);
        chk("midrst txn_len", {60'd0, txn_len}, 64'd0);
        chk("midrst endp",    {60'd0, txn_endp}, 64'd0);
        txn_done  = 1'b1;
        txn_ok    = 1'b1;
        txn_rdata = 64'h1111_2222_3333_4444;
        errs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            txn_done = 1'b0;
            if (resp_valid || txn_start) errs++;
        end
        chk("midrst quiet", 64'(errs), 64'd0);

        // Second request held on req_valid across the whole first request
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h1357;
        req_wdata = 64'h0123_4567_89AB_CDEF;
        txn_rdata = 64'h9999_8888_7777_6666;
        starts    = 0;
        resps     = 0;
        r1        = -1;
        done_cyc  = -1;
        ok2       = 1'b0;
        for (int cyc = 1; cyc < 60 && resps < 2; cyc++) begin
            @(negedge clk);
            txn_done = 1'b0;
            if (cyc == 1) begin
                req_write = 1'b0;
                req_addr  = 16'hBEEF;
            end
            if (txn_start) begin
                starts++;
                done_cyc = cyc + 1;
                if (starts == 3) begin
                    req_valid = 1'b0;
                    chk("busy accept_cycle", 64'(cyc), 64'(r1 + 2));
                    chk("busy second_addr",  txn_data, 64'h0000_0000_0000_BEEF);
                end
            end
            if (resp_valid) begin
                resps++;
                if (resps == 1) r1 = cyc;
                else ok2 = resp_success && (resp_rdata == 64'h9999_8888_7777_6666);
            end
            if (cyc == done_cyc) begin
                txn_done = 1'b1;
                txn_ok   = 1'b1;
            end
        end
        req_valid = 1'b0;
        txn_done  = 1'b0;
        chk("busy starts",     64'(starts), 64'd4);
        chk("busy second_ok",  {63'd0, ok2}, 64'd1);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            v.wr    = $urandom_range(0, 1) == 1;
            v.addr  = 16'($urandom);
            v.wdata = {$urandom, $urandom};
            v.rd    = {$urandom, $urandom};
            v.af    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
            v.df    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
            v.lat   = int'($urandom_range(0, 3));
            v       = model(v);
            run_req(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_rw_fsm.md
# usb_rw_fsm

Host-side read/write sequencer between the host's `writeData`/`readData` task front end and the USB protocol-transaction layer. Accepts one memory request (16-bit address, 64-bit data) at a time and turns it into two USB transactions:

- an OUT of the address to the address endpoint;
- then an OUT of the data (write) or an IN of the data (read) on the data endpoint.

It retries failed transactions and returns one success/fail response per request.

## Interface
Parameters:
- DEV_ADDR, 7'd5: USB device address driven on every transaction
- ADDR_ENDP, 4'd4: endpoint used for the address phase
- DATA_ENDP, 4'd8: endpoint used for the data phase
- MAX_RETRY, 8: total attempts allowed per phase (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  memory address
- req_wdata  in  64  write data
- resp_valid  out  1  one-cycle response strobe
- resp_success  out  1  request completed (valid only with resp_valid)
- resp_rdata  out  64  read data (valid only with resp_valid)
- txn_start  out  1  one-cycle transaction launch
- txn_kind  out  1  0 = OUT, 1 = IN
- txn_dev  out  7  device address (= DEV_ADDR)
- txn_endp  out  4  endpoint
- txn_len  out  4  payload bytes (2 for address, 8 for data, 0 for IN)
- txn_data  out  64  OUT payload, little-endian; address in bits [15:0], upper bits 0
- txn_done  in  1  one-cycle completion from protocol layer
- txn_ok  in  1  transaction ACKed / DATA received intact (sampled with txn_done)
- txn_rdata  in  64  IN payload (sampled with txn_done && txn_ok)

## Operation
- States: IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid: latch write/addr/wdata, clear the attempt counter, go to ADDR_ISSUE.
- **ADDR_ISSUE**
  - txn_start = 1 with OUT, ADDR_ENDP, len 2, data = {48'b0, addr}.
  - Increment the attempt counter; go to ADDR_WAIT.
- **ADDR_WAIT**
  - txn_done && txn_ok: clear the counter, go to DATA_ISSUE.
  - txn_done && !txn_ok with counter < MAX_RETRY: go to ADDR_ISSUE.
  - txn_done && !txn_ok with counter = MAX_RETRY: go to RESP with fail; the data phase is skipped.
- **DATA_ISSUE**
  - Write: OUT, DATA_ENDP, len 8, data = wdata.
  - Read: IN, DATA_ENDP, len 0, data = 0.
  - Increment the counter; go to DATA_WAIT.
- **DATA_WAIT**
  - Same retry rules as ADDR_WAIT.
  - On a read success, capture txn_rdata.
  - Success or exhaustion goes to RESP.
- **RESP**
  - resp_valid = 1 for one cycle; go to IDLE.
  - resp_rdata = captured data on a read success, otherwise 0.
- Attempt counter is $clog2(MAX_RETRY+1) bits wide and never wraps.
- txn_* outputs other than txn_start may hold their values between launches. They are 0 in IDLE.

## Timing
- Reset values: req_ready = 1; resp_valid, resp_success, resp_rdata, txn_start, txn_kind, txn_endp, txn_len, txn_data all = 0; txn_dev = DEV_ADDR. State = IDLE.
- Accept at cycle 0. txn_start is asserted in cycle 1 (address) and cycle 3 (data) at the earliest.
- Minimum response latency is 5 cycles after accept (txn_done in the first cycle of each WAIT state).
- Each retry adds 2 cycles plus the protocol-layer latency.
- txn_done is sampled only in the WAIT states. It is ignored in every other state, including a txn_done that is still in flight after reset.
- req_valid is ignored while req_ready = 0; the requester must hold it.
- A back-to-back request is accepted in the first IDLE cycle after RESP.
- rst asserted mid-operation: on the next edge return to IDLE with reset output values and discard the latched request. No response is issued.

## Structure
- Shared package `usb_pkg` holds:
  - `txn_kind_t` enum (TXN_OUT, TXN_IN);
  - `rw_state_t` enum;
  - constants ADDR_LEN = 2 and DATA_LEN = 8.
- Single module. The phase/retry counter is inline; no sub-module is required.

## Test plan
- **Write success:** req_write = 1, addr 16'hFFFF, wdata 64'hFFFF_FFFF_FFFF_FFFF, every txn_done returns ok.
  - Expect OUT ep4 data 64'h0000_0000_0000_FFFF len 2.
  - Then OUT ep8 data all-ones len 8.
  - Then resp_valid with success = 1 at cycle 5.
- **Read success:** addr 16'h0040, IN returns txn_rdata 64'hDEAD_BEEF_0123_4567 → resp_success = 1, resp_rdata = 64'hDEAD_BEEF_0123_4567.
- **Address retry:** first 2 address transactions return !ok, third returns ok → exactly 4 txn_start pulses in total, success = 1.
- **Data exhaustion:** every data transaction returns !ok → 1 + 8 txn_start pulses, then success = 0, rdata = 0.
- **Reset mid-op:** rst in DATA_WAIT, then a late txn_done → no resp_valid; req_ready = 1 the cycle after reset.
- **Busy hold:** second req_valid held during an active request → accepted only in the IDLE cycle after the first resp_valid.
